// File: rtl/core_pipe_fetch_ctrl.sv
// Fetch-stage controller: issues word-aligned imem requests under a credit limit,
// buffers responses for decode, and squashes in-flight fetches on a redirect.
module core_pipe_fetch_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] PC_RESET  = 64'h0000_0000_8000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            cf_valid,
  output logic            cf_ack,
  input  logic [XLEN-1:0] cf_target,
  output logic            imem_req,
  input  logic            imem_gnt,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_recv,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_error,
  output logic            f_valid,
  input  logic            f_ready,
  output logic [31:0]     f_data,
  output logic [XLEN-1:0] f_pc,
  output logic            f_error
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic {S_RUN = 1'b0, S_ERR = 1'b1} state_e;

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
    logic            err;
  } fb_entry_t;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              pend_q, pend_d;
  fb_entry_t         fb_q [BUF_DEPTH];
  fb_entry_t         head;

  logic              credit_ok;
  logic              issue_ok;
  logic              grant;
  logic              keep;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   target_al;

  assign target_al = cf_target & ~XLEN'(3);
  assign credit_ok = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW+1)'(BUF_DEPTH);
  assign grant     = imem_req && imem_gnt;
  assign keep      = imem_recv && (drop_q == '0) && !cf_ack;
  assign push      = keep;
  assign pop       = f_valid && f_ready;

  // FSM: state register
  always_ff @(posedge g_clk) begin
    if (g_reset) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (cf_ack) state_d = S_RUN;
               else if (keep && imem_error) state_d = S_ERR;
      S_ERR:   if (cf_ack) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs. A stalled request (pend_q) is held regardless of state or cf_valid;
  // new requests are suppressed while cf_valid is high so the redirect can be taken.
  always_comb begin
    issue_ok = 1'b0;
    case (state_q)
      S_RUN:   issue_ok = credit_ok;
      S_ERR:   issue_ok = 1'b0;
      default: issue_ok = 1'b0;
    endcase
    imem_req = !g_reset && (pend_q || (issue_ok && !cf_valid));
    cf_ack   = !g_reset && cf_valid && !(imem_req && !imem_gnt);
  end

  assign imem_addr = fetch_pc_q;

  always_comb begin
    pend_d     = imem_req && !imem_gnt;
    fetch_pc_d = grant ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d   = keep  ? rsp_pc_q + XLEN'(4)   : rsp_pc_q;

    case ({grant, imem_recv})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    drop_d = drop_q;
    if (imem_recv && (drop_q != '0)) drop_d = drop_q - CW'(1);

    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything still outstanding after this cycle belongs to the old stream.
    if (cf_ack) begin
      fetch_pc_d = target_al;
      rsp_pc_d   = target_al;
      drop_d     = outst_d;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      fetch_pc_q <= PC_RESET;
      rsp_pc_q   <= PC_RESET;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pend_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pend_q     <= pend_d;
    end
  end

  // Buffer storage needs no reset: outputs are masked while empty.
  always_ff @(posedge g_clk) begin
    if (push) fb_q[wr_ptr_q] <= '{data: imem_rdata, pc: rsp_pc_q, err: imem_error};
  end

  assign head    = fb_q[rd_ptr_q];
  assign f_valid = (cnt_q != '0);
  assign f_data  = f_valid ? head.data : '0;
  assign f_pc    = f_valid ? head.pc   : '0;
  assign f_error = f_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_core_pipe_fetch_ctrl.sv
// Bench for core_pipe_fetch_ctrl: in-order memory model plus a decode scoreboard.
`timescale 1ns/1ps
module tb_core_pipe_fetch_ctrl;
  localparam int          XLEN      = 64;
  localparam logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        g_clk, g_reset;
  logic        cf_valid, cf_ack;
  logic [63:0] cf_target;
  logic        imem_req, imem_gnt;
  logic [63:0] imem_addr;
  logic        imem_recv, imem_error;
  logic [31:0] imem_rdata;
  logic        f_valid, f_ready, f_error;
  logic [31:0] f_data;
  logic [63:0] f_pc;

  core_pipe_fetch_ctrl #(.XLEN(XLEN), .PC_RESET(PC_RESET), .BUF_DEPTH(BUF_DEPTH)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_recv(imem_recv), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .f_pc(f_pc), .f_error(f_error)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct { logic [63:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; logic err; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [63:0] grant_log[$];
  logic [63:0] pop_pc_log[$];
  int          passed, total;
  int          cyc, epoch, lat;
  int          n_grants, n_acks, n_pops, n_err_pops;
  bit          rsp_hold, prev_stall;
  logic [63:0] err_addr, exp_pc, prev_addr;

  function automatic logic [31:0] memword(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], 16'h5A3C};
  endfunction

  // One clock cycle: drive the memory response, sample just before the edge,
  // then update the model with what the DUT committed at that edge.
  task automatic tick();
    exp_t        e;
    pend_t       p;
    logic        s_req, s_ack, s_fv, s_ferr;
    logic [63:0] s_addr, s_fpc;
    logic [31:0] s_fd;
    imem_recv = 1'b0; imem_rdata = '0; imem_error = 1'b0;
    if (!g_reset && !rsp_hold && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_recv  = 1'b1;
      imem_rdata = memword(pend_q[0].addr);
      imem_error = (pend_q[0].addr == err_addr);
    end
    #3;
    s_req = imem_req; s_addr = imem_addr; s_ack = cf_ack;
    s_fv = f_valid; s_fd = f_data; s_fpc = f_pc; s_ferr = f_error;
    if (!g_reset) begin
      total++;
      if (s_ack !== (cf_valid && !(s_req && !imem_gnt)))
        $display("FAIL cf_ack cyc=%0d got=%b exp=%b", cyc, s_ack, cf_valid && !(s_req && !imem_gnt));
      else passed++;
      if (prev_stall) begin
        total++;
        if (s_req !== 1'b1 || s_addr !== prev_addr)
          $display("FAIL stall_hold cyc=%0d req=%b addr=%h exp_addr=%h", cyc, s_req, s_addr, prev_addr);
        else passed++;
      end
      if (s_req) begin
        total++;
        if (pend_q.size() + exp_q.size() >= BUF_DEPTH)
          $display("FAIL credit cyc=%0d req=1 outstanding=%0d buffered=%0d", cyc, pend_q.size(), exp_q.size());
        else passed++;
      end
      total++;
      if (s_fv !== (exp_q.size() != 0))
        $display("FAIL f_valid cyc=%0d got=%b exp=%b", cyc, s_fv, exp_q.size() != 0);
      else passed++;
      if (s_fv && f_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_pops++;
        pop_pc_log.push_back(s_fpc);
        if (s_ferr) n_err_pops++;
        total++;
        if (s_fd !== e.data || s_fpc !== e.pc || s_ferr !== e.err)
          $display("FAIL pop cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, s_fd, s_fpc, s_ferr, e.data, e.pc, e.err);
        else passed++;
      end
      if (s_req && imem_gnt) begin
        total++;
        if (s_addr !== exp_pc) $display("FAIL grant_addr cyc=%0d got=%h exp=%h", cyc, s_addr, exp_pc);
        else passed++;
        grant_log.push_back(s_addr);
        n_grants++;
        pend_q.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
        exp_pc = s_addr + 64'd4;
      end
      if (imem_recv) begin
        p = pend_q.pop_front();
        if (p.epoch == epoch && !s_ack) begin
          total++;
          if (exp_q.size() >= BUF_DEPTH) $display("FAIL overflow cyc=%0d buffered=%0d", cyc, exp_q.size());
          else passed++;
          exp_q.push_back('{data: memword(p.addr), pc: p.addr, err: (p.addr == err_addr)});
        end
      end
      if (s_ack) begin
        n_acks++;
        epoch++;
        exp_q.delete();
        exp_pc = cf_target & ~64'h3;
      end
      prev_stall = s_req && !imem_gnt;
      prev_addr  = s_addr;
    end else prev_stall = 1'b0;
    @(posedge g_clk);
    @(negedge g_clk);
    cyc++;
  endtask

  task automatic reset_begin();
    g_reset = 1'b1; cf_valid = 1'b0; cf_target = '0; imem_gnt = 1'b0; f_ready = 1'b0;
    pend_q.delete(); exp_q.delete(); grant_log.delete(); pop_pc_log.delete();
    rsp_hold = 1'b0; lat = 1; err_addr = '1; epoch = 0; exp_pc = PC_RESET; prev_stall = 1'b0;
    n_grants = 0; n_acks = 0; n_pops = 0; n_err_pops = 0;
    tick(); tick();
  endtask

  task automatic do_reset();
    reset_begin();
    g_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_begin();
    total++;
    if ({imem_req, cf_ack, f_valid, f_error} !== 4'b0 || f_data !== '0 || f_pc !== '0)
      $display("FAIL reset_outs req=%b ack=%b fv=%b ferr=%b fd=%h fpc=%h", imem_req, cf_ack, f_valid, f_error, f_data, f_pc);
    else passed++;
    total++;
    if (imem_addr !== PC_RESET) $display("FAIL reset_addr got=%h exp=%h", imem_addr, PC_RESET);
    else passed++;
    g_reset = 1'b0; imem_gnt = 1'b1;
    repeat (4) tick();
    // Reset with requests and buffered words in flight.
    reset_begin();
    total++;
    if (f_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== PC_RESET)
      $display("FAIL midreset fv=%b req=%b addr=%h exp_addr=%h", f_valid, imem_req, imem_addr, PC_RESET);
    else passed++;
    g_reset = 1'b0; imem_gnt = 1'b1; f_ready = 1'b1;
    repeat (6) tick();
    total++;
    if (grant_log.size() < 1 || grant_log[0] !== PC_RESET)
      $display("FAIL midreset_restart grants=%0d first=%h exp=%h", grant_log.size(), grant_log.size() ? grant_log[0] : 64'hx, PC_RESET);
    else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt = 1'b1; f_ready = 1'b1;
    repeat (30) tick();
    total++;
    if (grant_log.size() < 3 || grant_log[0] !== 64'h8000_0000 || grant_log[1] !== 64'h8000_0004 || grant_log[2] !== 64'h8000_0008)
      $display("FAIL stream_addrs grants=%0d", grant_log.size());
    else passed++;
    total++;
    if (n_pops < 10) $display("FAIL stream_pops got=%0d exp>=10", n_pops);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1; f_ready = 1'b0;
    repeat (10) tick();
    total++;
    if (n_grants !== 2) $display("FAIL bp_grants got=%0d exp=2", n_grants);
    else passed++;
    total++;
    if (imem_req !== 1'b0) $display("FAIL bp_req got=%b exp=0", imem_req);
    else passed++;
    f_ready = 1'b1;
    for (int i = 0; i < 10 && n_grants < 3; i++) tick();
    total++;
    if (grant_log.size() < 3 || grant_log[2] !== 64'h8000_0008)
      $display("FAIL bp_resume grants=%0d exp_addr=80000008", grant_log.size());
    else passed++;
  endtask

  task automatic test_redirect();
    int a0;
    do_reset();
    imem_gnt = 1'b1; f_ready = 1'b1; rsp_hold = 1'b1;
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) tick();
    total++;
    if (pend_q.size() !== 2) $display("FAIL redir_setup outstanding=%0d exp=2", pend_q.size());
    else passed++;
    cf_valid = 1'b1; cf_target = 64'h8000_1003;
    a0 = n_acks;
    tick();
    total++;
    if (n_acks !== a0 + 1) $display("FAIL redir_ack got=%0d exp=%0d", n_acks - a0, 1);
    else passed++;
    cf_valid = 1'b0; rsp_hold = 1'b0;
    for (int i = 0; i < 20 && n_pops < 2; i++) tick();
    total++;
    if (grant_log.size() < 3 || grant_log[2] !== 64'h8000_1000)
      $display("FAIL redir_addr grants=%0d exp_addr=80001000", grant_log.size());
    else passed++;
    total++;
    if (pop_pc_log.size() < 1 || pop_pc_log[0] !== 64'h8000_1000)
      $display("FAIL redir_fpc pops=%0d exp=80001000", pop_pc_log.size());
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    imem_gnt = 1'b0; f_ready = 1'b1;
    tick();
    cf_valid = 1'b1; cf_target = 64'h2000;
    repeat (3) tick();
    total++;
    if (n_acks !== 0 || n_grants !== 0) $display("FAIL stall_noack acks=%0d grants=%0d exp=0/0", n_acks, n_grants);
    else passed++;
    imem_gnt = 1'b1;
    tick();
    total++;
    if (n_acks !== 1 || n_grants !== 1 || grant_log[0] !== PC_RESET)
      $display("FAIL stall_gnt acks=%0d grants=%0d exp=1/1", n_acks, n_grants);
    else passed++;
    cf_valid = 1'b0;
    repeat (10) tick();
    total++;
    if (grant_log.size() < 2 || grant_log[1] !== 64'h2000 || pop_pc_log.size() < 1 || pop_pc_log[0] !== 64'h2000)
      $display("FAIL stall_target grants=%0d pops=%0d exp_pc=2000", grant_log.size(), pop_pc_log.size());
    else passed++;
  endtask

  task automatic test_error();
    do_reset();
    imem_gnt = 1'b1; f_ready = 1'b1; err_addr = 64'h8000_0004;
    repeat (12) tick();
    total++;
    if (n_grants !== 2 || imem_req !== 1'b0) $display("FAIL err_hold grants=%0d req=%b exp=2/0", n_grants, imem_req);
    else passed++;
    total++;
    if (n_err_pops !== 1 || pop_pc_log.size() != 2 || pop_pc_log[1] !== 64'h8000_0004)
      $display("FAIL err_entry errpops=%0d pops=%0d exp=1/2", n_err_pops, pop_pc_log.size());
    else passed++;
    cf_valid = 1'b1; cf_target = 64'h100;
    tick();
    cf_valid = 1'b0;
    repeat (6) tick();
    total++;
    if (n_acks !== 1 || grant_log.size() < 3 || grant_log[2] !== 64'h100)
      $display("FAIL err_redirect acks=%0d grants=%0d exp_addr=100", n_acks, grant_log.size());
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_gnt = 1'b1; f_ready = 1'b1;
    cf_valid = 1'b1; cf_target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    cf_valid = 1'b0;
    repeat (8) tick();
    total++;
    if (grant_log.size() < 2 || grant_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || grant_log[1] !== 64'h0)
      $display("FAIL wrap_addr grants=%0d exp=fffffffffffffffc,0", grant_log.size());
    else passed++;
    total++;
    if (pop_pc_log.size() < 2 || pop_pc_log[0] !== 64'hFFFF_FFFF_FFFF_FFFC || pop_pc_log[1] !== 64'h0)
      $display("FAIL wrap_fpc pops=%0d exp=fffffffffffffffc,0", pop_pc_log.size());
    else passed++;
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0;
    g_reset = 1'b1; cf_valid = 1'b0; cf_target = '0; imem_gnt = 1'b0; f_ready = 1'b0;
    imem_recv = 1'b0; imem_rdata = '0; imem_error = 1'b0;
    @(negedge g_clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stall();
    test_error();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
